rr_grant_arbiter: RTL and testbench
===================================

// Module: rr_grant_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one resource among DECODE_WIDTH requesters.
//   Holds the winner as an ENCODE_WIDTH-bit index and drives a one-hot grant
//   (binary-to-one-hot decode of that index), all outputs registered.
//   A hold counter forces rotation after MAX_HOLD cycles when others wait.
//   Sits in front of any shared unit whose select lines come from a decoder.
//
// PARAMETERS
//   ENCODE_WIDTH  2                  width of winner index
//   DECODE_WIDTH  2**ENCODE_WIDTH    number of requesters; do not override
//   MAX_HOLD      8                  max consecutive grant cycles while others wait (>=1)
//
// PORTS
//   clk          in   1             single clock, all logic on posedge
//   rst          in   1             synchronous, active-high reset
//   req          in   DECODE_WIDTH  level request, bit i = requester i
//   grant        out  DECODE_WIDTH  one-hot grant; 0 when grant_valid=0
//   grant_idx    out  ENCODE_WIDTH  index of current owner
//   grant_valid  out  1             a requester currently owns the resource
//
// BEHAVIOUR
// - Reset values: state=IDLE; grant=0; grant_idx=0; grant_valid=0.
//   Internal reset values: ptr=0, hold_cnt=0. rst overrides all other inputs.
// - Invariant: grant == (grant_valid ? 1<<grant_idx : 0). Never more than one bit set.
// - Search: pick the first set req bit starting at ptr, then ptr+1 .. N-1, wrap
//   to 0 .. ptr-1. ptr = (last owner + 1) mod N, updated on every hand-off.
// - hold_cnt: width $clog2(MAX_HOLD+1). Set to 1 on any new grant. Increments
//   each cycle the same owner is kept, saturating at MAX_HOLD.
// - FSM states IDLE and BUSY. Latency is 1 cycle from a req edge to grant.
//   - IDLE: if req==0, stay in IDLE. Else take the search winner, go to BUSY,
//     and set grant_valid=1.
//   - BUSY, when req[owner]==0 (release): ptr<=owner+1. If any other req is
//     set, switch directly to the search winner with no idle bubble. Else go
//     to IDLE with grant=0.
//   - BUSY, when req[owner]==1 and hold_cnt==MAX_HOLD and another req is set:
//     preempt. ptr<=owner+1 and grant the search winner, which excludes the
//     owner.
//   - BUSY, when req[owner]==1 otherwise: keep the owner and bump hold_cnt.
//     A lone owner keeps the grant forever, with hold_cnt parked at MAX_HOLD.
// - Simultaneous release and new requests are resolved in the same edge by the
//   search from the updated ptr.
// - Reset mid-grant: grant drops on the reset edge. The first grant after reset
//   searches from 0.
// - Requests that rise and fall while another requester owns the resource are
//   not remembered; there is no queue.
//
// TESTING (ENCODE_WIDTH=2, MAX_HOLD=8)
//   1. rst=1 for 2 cycles with req=4'b1111 -> grant=0, valid=0 throughout;
//      first edge after rst=0 -> grant=4'b0001, idx=0.
//   2. req=4'b0100 from IDLE -> next edge grant=4'b0100, idx=2; req=0 ->
//      next edge grant=0, valid=0.
//   3. req=4'b1111 held -> grants 0001,0010,0100,1000,0001, each exactly 8 cycles.
//   4. Owner 3, req=4'b1010, then req[3] drops -> next edge grant=4'b0010
//      (wrap from ptr=0), no idle cycle.
//   5. req=4'b0001 for 20 cycles -> grant stays 0001; then req=4'b0101 ->
//      next edge grant=4'b0100.
//   6. rst pulsed while idx=2 is granted -> grant=0 on the next edge; after
//      release, req=4'b1100 -> idx=2 (search from ptr=0).

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
// Round-robin arbiter for DECODE_WIDTH requesters. The winner is held as an
// index and decoded to a one-hot grant; every output comes straight from a
// flop. A hold counter forces rotation once an owner has held the resource
// for MAX_HOLD consecutive cycles while someone else is waiting.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | nobody owns the resource, grant is all zeros
// BUSY  | requester grant_idx owns the resource, hold_cnt counts its tenure

module rr_grant_arbiter #(
    parameter int ENCODE_WIDTH = 2,
    parameter int DECODE_WIDTH = 2 ** ENCODE_WIDTH,
    parameter int MAX_HOLD     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DECODE_WIDTH-1:0] req,
    output logic [DECODE_WIDTH-1:0] grant,
    output logic [ENCODE_WIDTH-1:0] grant_idx,
    output logic                    grant_valid
);

    localparam int HOLD_WIDTH = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_WIDTH-1:0]   HOLD_MAX = HOLD_WIDTH'(MAX_HOLD);
    localparam logic [HOLD_WIDTH-1:0]   HOLD_ONE = HOLD_WIDTH'(1);
    localparam logic [ENCODE_WIDTH-1:0] IDX_ONE  = ENCODE_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ENCODE_WIDTH-1:0] ptr, ptr_nxt;
    logic [ENCODE_WIDTH-1:0] idx_nxt;
    logic                    valid_nxt;
    logic [DECODE_WIDTH-1:0] grant_nxt;
    logic [HOLD_WIDTH-1:0]   hold_cnt, hold_nxt;

    logic [ENCODE_WIDTH-1:0] next_owner;
    logic [ENCODE_WIDTH-1:0] search_start;
    logic [DECODE_WIDTH-1:0] search_mask;
    logic [DECODE_WIDTH-1:0] owner_onehot;
    logic                    owner_req;
    logic                    found;
    logic [ENCODE_WIDTH-1:0] winner;
    logic [ENCODE_WIDTH-1:0] cand;

    // Owner-relative helpers. N is a power of two, so owner+1 wraps for free.
    always_comb begin
        next_owner   = grant_idx + IDX_ONE;
        owner_onehot = '0;
        owner_onehot[grant_idx] = 1'b1;
        owner_req    = req[grant_idx];
    end

    // Choose where the search starts and which requesters it may pick. While
    // busy the search always starts just past the owner and never returns the
    // owner itself, which covers both release and preemption.
    always_comb begin
        search_start = ptr;
        search_mask  = req;
        if (state == BUSY) begin
            search_start = next_owner;
            search_mask  = req & ~owner_onehot;
        end
    end

    // Rotating priority search: scanning offsets from high to low leaves the
    // lowest offset from search_start as the winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = DECODE_WIDTH - 1; i >= 0; i--) begin
            cand = search_start + ENCODE_WIDTH'(i);
            if (search_mask[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = grant_idx;
        valid_nxt = grant_valid;
        hold_nxt  = hold_cnt;

        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    idx_nxt   = winner;
                    valid_nxt = 1'b1;
                    hold_nxt  = HOLD_ONE;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    // Release: hand straight to the next requester if any.
                    ptr_nxt = next_owner;
                    if (found) begin
                        idx_nxt  = winner;
                        hold_nxt = HOLD_ONE;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        hold_nxt  = '0;
                    end
                end else if (hold_cnt == HOLD_MAX && found) begin
                    // Tenure used up and someone else is waiting: preempt.
                    ptr_nxt  = next_owner;
                    idx_nxt  = winner;
                    hold_nxt = HOLD_ONE;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_nxt = hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase

        grant_nxt = '0;
        if (valid_nxt) begin
            grant_nxt[idx_nxt] = 1'b1;
        end
    end

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            grant       <= grant_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter (ENCODE_WIDTH=2, MAX_HOLD=8).
// The stimulus process drives one cycle of inputs and queues the hand-computed
// outputs expected after that edge; the monitor pops and compares them.

module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
        logic       chk_idx;
        string      name;
        int         step_no;
    } exp_t;

    exp_t exp_q[$];
    int   step_cnt = 0;

    rr_grant_arbiter #(
        .ENCODE_WIDTH(2),
        .DECODE_WIDTH(4),
        .MAX_HOLD    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                        input logic [1:0] ei, input logic ev, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
        e.grant   = eg;
        e.idx     = ei;
        e.valid   = ev;
        e.chk_idx = ev | r;
        e.name    = nm;
        e.step_no = step_cnt;
        step_cnt++;
        exp_q.push_back(e);
    endtask

    task automatic steps(input int n, input logic [3:0] rq, input logic [3:0] eg,
                         input logic [1:0] ei, input logic ev, input string nm);
        for (int k = 0; k < n; k++) step(1'b0, rq, eg, ei, ev, nm);
    endtask

    // Monitor: outputs are registered, so sample at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (grant !== e.grant || grant_valid !== e.valid ||
                    (e.chk_idx && grant_idx !== e.idx)) begin
                    errors++;
                    $display("FAIL %s step %0d: got grant=%b idx=%0d valid=%b, want grant=%b idx=%0d valid=%b",
                             e.name, e.step_no, grant, grant_idx, grant_valid,
                             e.grant, e.idx, e.valid);
                end
            end
        end
    end

    initial begin
        // Reset held with all requests up: nothing granted.
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset_hold");
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset_hold");

        // Full load: each requester gets exactly 8 cycles, first one is 0.
        steps(8, 4'b1111, 4'b0001, 2'd0, 1'b1, "rotate_r0");
        steps(8, 4'b1111, 4'b0010, 2'd1, 1'b1, "rotate_r1");
        steps(8, 4'b1111, 4'b0100, 2'd2, 1'b1, "rotate_r2");
        steps(8, 4'b1111, 4'b1000, 2'd3, 1'b1, "rotate_r3");
        steps(8, 4'b1111, 4'b0001, 2'd0, 1'b1, "rotate_r0_again");
        steps(1, 4'b0000, 4'b0000, 2'd0, 1'b0, "release_all");

        // Single request from idle, then release.
        steps(1, 4'b0100, 4'b0100, 2'd2, 1'b1, "idle_grant_r2");
        steps(1, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_after_r2");

        // Owner 3, owner drops while 1 waits: direct hand-off wrapping to 1.
        steps(1, 4'b1000, 4'b1000, 2'd3, 1'b1, "grant_r3");
        steps(1, 4'b1010, 4'b1000, 2'd3, 1'b1, "r3_keeps");
        steps(1, 4'b0010, 4'b0010, 2'd1, 1'b1, "wrap_handoff_r1");
        steps(1, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_after_r1");

        // Lone owner keeps the grant indefinitely, then is preempted.
        steps(20, 4'b0001, 4'b0001, 2'd0, 1'b1, "lone_owner_r0");
        steps(1, 4'b0101, 4'b0100, 2'd2, 1'b1, "preempt_to_r2");

        // Reset mid-grant, then first grant searches from 0.
        step(1'b1, 4'b0101, 4'b0000, 2'd0, 1'b0, "reset_mid_grant");
        steps(1, 4'b0000, 4'b0000, 2'd0, 1'b0, "post_reset_idle");
        steps(3, 4'b1100, 4'b0100, 2'd2, 1'b1, "post_reset_r2");

        // Release plus new requests in the same edge: search from owner+1.
        steps(1, 4'b1011, 4'b1000, 2'd3, 1'b1, "swap_to_r3");
        steps(1, 4'b0011, 4'b0001, 2'd0, 1'b1, "swap_to_r0");
        steps(1, 4'b0000, 4'b0000, 2'd0, 1'b0, "final_idle");

        // Let the monitor drain, bounded.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
